dp_pair_ctrl: RTL and testbench
===============================

# dp_pair_ctrl

Sequencing controller for the pairwise add/subtract datapath: the 8×8 memory A, 4×8 memory B, address counters A and B, two operand registers, comparator, adder/subtractor and result mux. On `start` it optionally loads 8 words into memory A, then walks the four word pairs (A[2k], A[2k+1]). For each pair it writes A[2k]−A[2k+1] into B[k] when A[2k] ≥ A[2k+1], and A[2k]+A[2k+1] otherwise. It issues only control strobes and never touches data.

## Interface
Parameters: none; widths are fixed by the datapath.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and all outputs low.
- `start`  in  1  begin a run; sampled in IDLE only.
- `load_valid`  in  1  external word present on memory-A data input (LOAD phase).
- `sign`  in  1  comparator output; 1 when reg1 < reg2.
- `wea`  out  1  memory A write enable.
- `inc_a` / `clr_a`  out  1  counter A increment / clear.
- `inc_b` / `clr_b`  out  1  counter B increment / clear.
- `ld_r1` / `ld_r2`  out  1  load operand register 1 / 2 from memory A output.
- `sel`  out  1  mux select: 1 selects adder, 0 selects subtractor.
- `web`  out  1  memory B write enable.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at run completion.

## Operation
- States: IDLE, LOAD, RD1, RD2, CMP, WR, DONE. Encoding is registered, 3 bits.
- IDLE:
  - All strobes low.
  - On `start`=1: assert `clr_a` and `clr_b` for that cycle, then go to LOAD.
- LOAD:
  - `wea` = `inc_a` = `load_valid` (combinational).
  - An internal 3-bit word count increments per accepted word.
  - After the 8th accepted word, go to RD1. Counter A wraps 7→0 naturally, so it needs no clear.
  - `load_valid` gaps stall LOAD indefinitely.
- RD1: `ld_r1`=1, `inc_a`=1; go to RD2.
- RD2: `ld_r2`=1, `inc_a`=1; go to CMP.
- CMP: `sel` register ← `sign`; no strobes; go to WR.
- WR:
  - `web`=1, `inc_b`=1.
  - Internal 2-bit pair count increments.
  - If the pair count was 3, go to DONE; otherwise go to RD1.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `sel` holds its value from CMP until the next CMP, and is 0 after reset.
- `start` while `busy`: ignored.
- `start` held high through DONE: a new run begins on the IDLE cycle that follows.
- `reset` mid-run:
  - Immediate return to IDLE; internal counts cleared; all outputs 0.
  - Datapath counters are not touched until the next `start` issues `clr_a`/`clr_b`.
- Counter contract: the datapath counters act on the clock edge that ends the cycle in which `inc_*`/`clr_*` is high.

## Timing
- Reset values: `wea`, `inc_a`, `clr_a`, `inc_b`, `clr_b`, `ld_r1`, `ld_r2`, `web`, `sel`, `busy`, `done` are all 0.
- Let cycle 0 be the IDLE cycle in which `start`=1. With back-to-back `load_valid`:
  - LOAD occupies cycles 1–8.
  - Pairs k=0..3 occupy cycles 9+4k … 12+4k in the order RD1, RD2, CMP, WR.
  - `done` is high in cycle 25; IDLE is in cycle 26.
- `busy` rises in cycle 1 and falls in cycle 26.
- `sign` is sampled in CMP, one cycle after `ld_r2`. The comparator must settle within that cycle.
- Each pair takes exactly 4 cycles; the processing phase is exactly 16 cycles.

## Configuration
- `DPCTL_LOAD_EN` defined: LOAD state present, behaviour as above.
- `DPCTL_LOAD_EN` undefined:
  - LOAD state and word count are removed; memory A is preloaded.
  - IDLE + `start` goes directly to RD1 (with `clr_a`/`clr_b`).
  - `wea` is tied 0; `load_valid` is ignored.
  - `done` is high in cycle 17.

## Test plan
- Reset behaviour: assert `reset` asynchronously mid-cycle → all outputs 0 immediately, `busy`=0; next `start` runs normally from a clean state.
- Full run: load A = {10, 3, 4, 9, 7, 7, 0, 255} back-to-back, then drive `sign` from a comparator model →
  - B = {7, 13, 0, 255};
  - `sel` = 0, 1, 0, 1 in successive WR cycles;
  - `done` in cycle 25.
- LOAD stall: drop `load_valid` for 3 cycles after word 4 → `wea`/`inc_a` low during the gap; `done` moves to cycle 28; B results unchanged.
- Mid-run reset: assert `reset` in the CMP cycle of pair 1 → IDLE, no `web`; a restart completes with the correct B contents.
- Ignored start: pulse `start` during RD2 → no effect on sequence or timing; held `start` after DONE begins a second run at cycle 26.
- Macro off: build without `DPCTL_LOAD_EN` and preload A → `wea` never asserts, RD1 in cycle 1, `done` in cycle 17.

Source files
------------

// File: rtl/dp_pair_ctrl.sv
//-----------------------------------------------------------------------------
// dp_pair_ctrl
// Sequencing controller for the pairwise add/subtract datapath (memory A 8x8,
// memory B 4x8, address counters A/B, two operand registers, comparator,
// adder/subtractor and result mux). It issues control strobes only.
//
// Build option: define DPCTL_LOAD_EN to include the LOAD phase, in which
// 8 external words are written into memory A before processing. Without it,
// memory A is assumed preloaded and a run starts directly at the first read.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module dp_pair_ctrl (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_load_valid,
    input  logic i_sign,
    output logic o_wea,
    output logic o_inc_a,
    output logic o_clr_a,
    output logic o_inc_b,
    output logic o_clr_b,
    output logic o_ld_r1,
    output logic o_ld_r2,
    output logic o_sel,
    output logic o_web,
    output logic o_busy,
    output logic o_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
`ifdef DPCTL_LOAD_EN
    localparam logic [2:0] S_LOAD = 3'd1;
`endif
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_CMP  = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [1:0] r_pair_cnt;
    logic       r_sel;
    logic       w_start_run;

    // A run is launched only from IDLE; start is ignored in every other state.
    assign w_start_run = (r_state == S_IDLE) && i_start;

`ifdef DPCTL_LOAD_EN
    logic [2:0] r_word_cnt;
`else
    // load_valid has no meaning when memory A is preloaded.
    logic w_unused_load_valid;
    assign w_unused_load_valid = i_load_valid;
`endif

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
`ifdef DPCTL_LOAD_EN
                    w_state_next = S_LOAD;
`else
                    w_state_next = S_RD1;
`endif
                end
            end
`ifdef DPCTL_LOAD_EN
            S_LOAD: begin
                // Leave after the 8th accepted word; gaps simply stall here.
                if (i_load_valid && (r_word_cnt == 3'd7)) begin
                    w_state_next = S_RD1;
                end
            end
`endif
            S_RD1:   w_state_next = S_RD2;
            S_RD2:   w_state_next = S_CMP;
            S_CMP:   w_state_next = S_WR;
            S_WR:    w_state_next = (r_pair_cnt == 2'd3) ? S_DONE : S_RD1;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef DPCTL_LOAD_EN
    // Count accepted load words; wraps back to 0 after the 8th word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_word_cnt <= 3'd0;
        end else if (w_start_run) begin
            r_word_cnt <= 3'd0;
        end else if ((r_state == S_LOAD) && i_load_valid) begin
            r_word_cnt <= r_word_cnt + 3'd1;
        end
    end
`endif

    // Count processed pairs; one step per WR, wraps after the 4th pair.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pair_cnt <= 2'd0;
        end else if (w_start_run) begin
            r_pair_cnt <= 2'd0;
        end else if (r_state == S_WR) begin
            r_pair_cnt <= r_pair_cnt + 2'd1;
        end
    end

    // Capture the comparator in CMP; held until the next pair's CMP.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sel <= 1'b0;
        end else if (r_state == S_CMP) begin
            r_sel <= i_sign;
        end
    end

    // Strobe decode from the current state.
    always_comb begin
        o_wea   = 1'b0;
        o_inc_a = 1'b0;
        o_clr_a = 1'b0;
        o_inc_b = 1'b0;
        o_clr_b = 1'b0;
        o_ld_r1 = 1'b0;
        o_ld_r2 = 1'b0;
        o_web   = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so a start held during reset issues no clear.
                o_clr_a = i_start && !i_reset;
                o_clr_b = i_start && !i_reset;
            end
`ifdef DPCTL_LOAD_EN
            S_LOAD: begin
                o_wea   = i_load_valid;
                o_inc_a = i_load_valid;
            end
`endif
            S_RD1: begin
                o_ld_r1 = 1'b1;
                o_inc_a = 1'b1;
            end
            S_RD2: begin
                o_ld_r2 = 1'b1;
                o_inc_a = 1'b1;
            end
            S_WR: begin
                o_web   = 1'b1;
                o_inc_b = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_sel  = r_sel;
    assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_dp_pair_ctrl.sv
//-----------------------------------------------------------------------------
// tb_dp_pair_ctrl
// Drives dp_pair_ctrl against a behavioural model of the datapath (memories,
// counters, operand registers, comparator). Expected strobes per cycle are
// derived from the cycle position within a run; expected memory-B contents
// come from the pair rule (a>=b ? a-b : a+b).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dp_pair_ctrl;

`ifdef DPCTL_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    typedef logic [7:0][7:0] words_t;
    typedef logic [3:0][7:0] bytes4_t;

    typedef struct {
        words_t  w;
        int      gap_after;
        int      gap_len;
        int      pulse_rel;
        bit      hold;
        bytes4_t exp_b;
        int      exp_done_on;
        int      exp_done_off;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, load_valid, sign;
    logic wea, inc_a, clr_a, inc_b, clr_b, ld_r1, ld_r2, sel, web, busy, done;

    dp_pair_ctrl dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_load_valid (load_valid),
        .i_sign       (sign),
        .o_wea        (wea),
        .o_inc_a      (inc_a),
        .o_clr_a      (clr_a),
        .o_inc_b      (inc_b),
        .o_clr_b      (clr_b),
        .o_ld_r1      (ld_r1),
        .o_ld_r2      (ld_r2),
        .o_sel        (sel),
        .o_web        (web),
        .o_busy       (busy),
        .o_done       (done)
    );

    // Datapath model.
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [4];
    logic [2:0] cnt_a = 3'd0;
    logic [1:0] cnt_b = 2'd0;
    logic [7:0] r1 = 8'd0;
    logic [7:0] r2 = 8'd0;
    logic [7:0] load_data;
    logic       pre_en;
    logic [7:0] pre_data [8];

    assign sign = (r1 < r2);

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 8; i++) mem_a[i] <= pre_data[i];
            for (int j = 0; j < 4; j++) mem_b[j] <= 8'hEE;
        end
        if (wea) mem_a[cnt_a] <= load_data;
        if (ld_r1) r1 <= mem_a[cnt_a];
        if (ld_r2) r2 <= mem_a[cnt_a];
        if (web) mem_b[cnt_b] <= sel ? (r1 + r2) : (r1 - r2);
        if (clr_a) cnt_a <= 3'd0;
        else if (inc_a) cnt_a <= cnt_a + 3'd1;
        if (clr_b) cnt_b <= 2'd0;
        else if (inc_b) cnt_b <= cnt_b + 2'd1;
    end

    int   checks = 0;
    int   failures = 0;
    logic last_sel = 1'b0;

    function automatic logic [10:0] outs();
        return {wea, inc_a, clr_a, inc_b, clr_b, ld_r1, ld_r2, sel, web, busy, done};
    endfunction

    function automatic words_t w8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        words_t w;
        w[0] = a0[7:0]; w[1] = a1[7:0]; w[2] = a2[7:0]; w[3] = a3[7:0];
        w[4] = a4[7:0]; w[5] = a5[7:0]; w[6] = a6[7:0]; w[7] = a7[7:0];
        return w;
    endfunction

    function automatic bytes4_t b4(input int a0, a1, a2, a3);
        bytes4_t b;
        b[0] = a0[7:0]; b[1] = a1[7:0]; b[2] = a2[7:0]; b[3] = a3[7:0];
        return b;
    endfunction

    function automatic logic [7:0] ref_pair(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (a + b);
    endfunction

    // Expected strobes at cycle t of a run whose first RD1 is cycle p0.
    // Bits: wea inc_a clr_a inc_b clr_b ld_r1 ld_r2 sel web busy done.
    function automatic logic [10:0] exp_vec(input int t, input int p0, input logic lv, input logic sv);
        logic [10:0] e;
        int ph;
        e = '0;
        e[3] = sv;
        if (t == 0) begin
            e[8] = 1'b1; e[6] = 1'b1;
        end else if (t < p0) begin
            e[1] = 1'b1; e[10] = lv; e[9] = lv;
        end else if (t < p0 + 16) begin
            e[1] = 1'b1;
            ph = (t - p0) % 4;
            case (ph)
                0: begin e[5] = 1'b1; e[9] = 1'b1; end
                1: begin e[4] = 1'b1; e[9] = 1'b1; end
                3: begin e[2] = 1'b1; e[7] = 1'b1; end
                default: ;
            endcase
        end else begin
            e[1] = 1'b1; e[0] = 1'b1;
        end
        return e;
    endfunction

    task automatic check_vec(input string name, input int t, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%b required=%b", name, t, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0; load_valid = 1'b0; pre_en = 1'b0;
            @(negedge clk);
            check_vec("idle", i, outs(), {7'b0, last_sel, 3'b0});
            @(posedge clk); #1;
        end
    endtask

    // One run starting with start=1 in the current (IDLE) cycle.
    task automatic run_job(input words_t w, input int gap_after, input int gap_len,
                           input int pulse_rel, input bit hold, input int abort_rel,
                           output int done_t);
        int p0;
        int last;
        int k;
        logic lv;
        logic sv;
        p0 = LOAD_EN ? (9 + gap_len) : 1;
        last = p0 + 16;
        done_t = -1;
        for (int i = 0; i < 8; i++) pre_data[i] = LOAD_EN ? ~w[i] : w[i];
        for (int t = 0; t <= last; t++) begin
            start = (t == 0) || (pulse_rel >= 0 && t == p0 + pulse_rel) || (hold && t >= last - 1);
            pre_en = (t == 0);
            lv = 1'b0;
            load_data = 8'h00;
            if (LOAD_EN && t >= 1 && t < p0) begin
                if (!(t >= 1 + gap_after && t < 1 + gap_after + gap_len)) begin
                    lv = 1'b1;
                    load_data = w[(t >= 1 + gap_after + gap_len) ? (t - 1 - gap_len) : (t - 1)];
                end
            end
            load_valid = lv;
            sv = last_sel;
            if (t >= p0 + 3) begin
                k = (t - p0 - 3) / 4;
                if (k > 3) k = 3;
                sv = (w[2*k] < w[2*k+1]);
            end
            @(negedge clk);
            check_vec("ctl", t, outs(), exp_vec(t, p0, lv, sv));
            if (done && done_t < 0) done_t = t;
            if (abort_rel >= 0 && t == p0 + abort_rel) begin
                #2 rst = 1'b1;
                #1 check_vec("async_rst", t, outs(), 11'b0);
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0; load_valid = 1'b0; pre_en = 1'b0;
                last_sel = 1'b0;
                $display("run aborted by reset at cycle %0d", t);
                return;
            end
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
        last_sel = (w[6] < w[7]);
        $display("run complete done_cycle=%0d B=%0d,%0d,%0d,%0d",
                 done_t, mem_b[0], mem_b[1], mem_b[2], mem_b[3]);
    endtask

    task automatic check_b(input bytes4_t eb);
        for (int k = 0; k < 4; k++) check_int("b_word", int'(mem_b[k]), int'(eb[k]));
    endtask

    vec_t tbl [5];

    initial begin
        int      dt;
        words_t  rw;
        bytes4_t rb;
        int      ga, gl, pr;

        tbl[0] = '{w8(10, 3, 4, 9, 7, 7, 0, 255),    0, 0, -1, 1'b0, b4(7, 13, 0, 255),   25, 17};
        tbl[1] = '{w8(10, 3, 4, 9, 7, 7, 0, 255),    4, 3, -1, 1'b0, b4(7, 13, 0, 255),   28, 17};
        tbl[2] = '{w8(0, 0, 255, 255, 1, 2, 200, 100), 0, 0, 1, 1'b0, b4(0, 0, 3, 100),   25, 17};
        tbl[3] = '{w8(5, 6, 128, 128, 255, 1, 3, 250), 0, 0, -1, 1'b1, b4(11, 0, 254, 253), 25, 17};
        tbl[4] = '{w8(1, 2, 3, 4, 5, 6, 7, 8),       0, 0, -1, 1'b0, b4(3, 7, 11, 15),    25, 17};

        rst = 1'b1; start = 1'b0; load_valid = 1'b0; pre_en = 1'b0; load_data = 8'h00;
        for (int i = 0; i < 8; i++) pre_data[i] = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset", 0, outs(), 11'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Table-driven runs; a held-start entry chains straight into the next.
        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].w, tbl[i].gap_after, tbl[i].gap_len, tbl[i].pulse_rel, tbl[i].hold, -1, dt);
            check_int("done_cycle", dt, LOAD_EN ? tbl[i].exp_done_on : tbl[i].exp_done_off);
            check_b(tbl[i].exp_b);
            if (!tbl[i].hold) idle(2);
        end

        // Reset in the CMP cycle of pair 1, then restart cleanly.
        run_job(tbl[0].w, 0, 0, -1, 1'b0, 6, dt);
        idle(3);
        run_job(tbl[0].w, 0, 0, -1, 1'b0, -1, dt);
        check_int("restart_done", dt, LOAD_EN ? 25 : 17);
        check_b(tbl[0].exp_b);
        idle(1);

        // Randomized runs against the pair rule.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) rw[i] = 8'($urandom);
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 3) == 0) rw[2*k+1] = rw[2*k];
            for (int k = 0; k < 4; k++) rb[k] = ref_pair(rw[2*k], rw[2*k+1]);
            ga = LOAD_EN ? int'($urandom_range(0, 7)) : 0;
            gl = LOAD_EN ? int'($urandom_range(0, 4)) : 0;
            pr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
            run_job(rw, ga, gl, pr, 1'b0, -1, dt);
            check_int("rand_done", dt, LOAD_EN ? (25 + gl) : 17);
            check_b(rb);
            idle(int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
